// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the 8259A acknowledge sequencer.
package pic_pkg;
   typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;
   localparam logic [2:0] NS_EOI = 3'b001;
   localparam logic [2:0] SP_EOI = 3'b011;
   localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;
endpackage

// File: rtl/priority_resolver.sv
// priority_resolver: 8-bit lowest-index-wins encoder with valid flag.
module priority_resolver (
   input  logic [7:0] req,
   output logic [2:0] level,
   output logic       valid
);
   always_comb begin
      level = '0;
      for (int i = 7; i >= 0; i--) if (req[i]) level = 3'(i);
   end
   assign valid = |req;
endmodule

// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer: INTA handshake FSM, ISR ownership, EOI handling and vector output.
module interrupt_ack_sequencer
   import pic_pkg::*;
#(
   parameter logic [4:0] VECTOR_BASE_RESET = 5'b00000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] internal_bus,
   input  logic       ICW_1_flag,
   input  logic       ICW_2_flag,
   input  logic       ICW_4_flag,
   input  logic       OCW_2_flag,
   input  logic [7:0] interrupt_request,
   input  logic       inta_bar,
   output logic       INT,
   output logic [7:0] clear_irr,
   output logic [7:0] in_service,
   output logic [7:0] vector_out,
   output logic       vector_out_en
);
   state_t     state_q, state_d;
   logic       inta_prev_q, aeoi_q, aeoi_d, int_q, int_d, voe_q, voe_d, spur_q, spur_d;
   logic [4:0] base_q, base_d;
   logic [2:0] lvl_q, lvl_d, req_lvl, isr_lvl;
   logic [7:0] isr_q, isr_d, clr_q, clr_d, vo_q, vo_d, set_mask, eoi_mask, aeoi_mask;
   logic       req_valid, isr_valid, fall, rise;

   priority_resolver u_req (.req(interrupt_request), .level(req_lvl), .valid(req_valid));
   priority_resolver u_isr (.req(isr_q), .level(isr_lvl), .valid(isr_valid));

   always_comb begin
      fall = inta_prev_q & ~inta_bar;
      rise = ~inta_prev_q & inta_bar;
      // non-specific EOI on an empty ISR targets bit 0, which is already clear
      eoi_mask = !OCW_2_flag ? '0 :
                 internal_bus[7:5] == NS_EOI ? 8'(1) << isr_lvl :
                 internal_bus[7:5] == SP_EOI ? 8'(1) << internal_bus[2:0] : '0;
      set_mask = '0;
      aeoi_mask = '0;
      state_d = state_q;
      lvl_d = lvl_q;
      spur_d = spur_q;
      clr_d = '0;
      vo_d = vo_q;
      voe_d = voe_q;
      case (state_q)
         IDLE: if (fall) begin
            state_d = ACK1;
            lvl_d = req_valid ? req_lvl : SPURIOUS_LEVEL;
            spur_d = ~req_valid;
            set_mask = req_valid ? 8'(1) << req_lvl : '0;
            clr_d = set_mask;
         end
         ACK1: state_d = WAIT2;
         WAIT2: if (fall) begin
            state_d = ACK2;
            vo_d = {base_q, lvl_q};
            voe_d = 1'b1;
         end
         ACK2: if (rise) begin
            state_d = IDLE;
            voe_d = 1'b0;
            aeoi_mask = (aeoi_q && !spur_q) ? 8'(1) << lvl_q : '0;
         end
      endcase
      isr_d = (isr_q & ~eoi_mask & ~aeoi_mask) | set_mask;
      base_d = ICW_2_flag ? internal_bus[7:3] : base_q;
      aeoi_d = ICW_4_flag ? internal_bus[1] : aeoi_q;
      int_d = req_valid & (~isr_valid | (req_lvl < isr_lvl));
      if (ICW_1_flag) begin
         state_d = IDLE;
         isr_d = '0;
         clr_d = '0;
         aeoi_d = 1'b0;
         voe_d = 1'b0;
         base_d = base_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         inta_prev_q <= 1'b1;
         base_q <= VECTOR_BASE_RESET;
         aeoi_q <= 1'b0;
         isr_q <= '0;
         int_q <= 1'b0;
         clr_q <= '0;
         vo_q <= '0;
         voe_q <= 1'b0;
         lvl_q <= '0;
         spur_q <= 1'b0;
      end else begin
         state_q <= state_d;
         inta_prev_q <= inta_bar;
         base_q <= base_d;
         aeoi_q <= aeoi_d;
         isr_q <= isr_d;
         int_q <= int_d;
         clr_q <= clr_d;
         vo_q <= vo_d;
         voe_q <= voe_d;
         lvl_q <= lvl_d;
         spur_q <= spur_d;
      end
   end

   assign INT = int_q;
   assign clear_irr = clr_q;
   assign in_service = isr_q;
   assign vector_out = vo_q;
   assign vector_out_en = voe_q;
endmodule

// File: doc/interrupt_ack_sequencer.md
# interrupt_ack_sequencer

Synchronous controller that runs the 8259A interrupt-acknowledge handshake and owns the In-Service Register (ISR). It sits between the Read/Write logic and the CPU-facing INT/INTA pins. It takes configuration and EOI commands from the decoded command-word flags and internal_bus, and takes pending requests from the IRR/mask stage. It drives INT, sets and clears ISR bits, and places the interrupt vector on the data bus during the second INTA pulse.

## Interface
- Parameters:
- VECTOR_BASE_RESET, 5'b00000, value of vector bits T7–T3 after reset and before ICW2
- Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- internal_bus  in  8  command byte from the Read/Write logic
- ICW_1_flag, ICW_2_flag, ICW_4_flag, OCW_2_flag  in  1 each  one-cycle pulses qualifying internal_bus
- interrupt_request  in  8  masked pending requests (bit n = IRn)
- inta_bar  in  1  CPU acknowledge, already synchronised to clk, active-low
- INT  out  1  interrupt request to the CPU
- clear_irr  out  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit
- in_service  out  8  ISR contents
- vector_out  out  8  vector byte for the data bus buffer
- vector_out_en  out  1  high while the vector is driven

## Operation
- Priority is fully nested: IR0 is highest, IR7 is lowest.
- Config registers: vector_base[4:0] takes internal_bus[7:3] on ICW_2_flag. aeoi takes internal_bus[1] on ICW_4_flag.
- ICW_1_flag clears in_service and aeoi, forces the FSM to IDLE and deasserts vector_out_en. vector_base is kept.
- INT is asserted when the highest set bit of interrupt_request has priority strictly above the highest set ISR bit, or when ISR is empty.
- Edge detect: fall = inta_prev & ~inta_bar. rise = ~inta_prev & inta_bar. inta_prev resets to 1.
- FSM states and transitions:
  - IDLE: on fall, go to ACK1.
  - ACK1 (entry cycle): latch level L = priority winner of interrupt_request. If there is a request, set in_service[L] and pulse clear_irr[L]. If interrupt_request == 0 (spurious), set L = 7, do not touch ISR, do not pulse clear_irr. Then go to WAIT2.
  - WAIT2: on fall, go to ACK2.
  - ACK2: drive vector_out = {vector_base, L[2:0]} with vector_out_en = 1 while inta_bar is low. On rise, drop vector_out_en. If aeoi is set and the cycle was not spurious, clear in_service[L]. Return to IDLE.
- OCW2 is accepted in any state, on OCW_2_flag:
  - internal_bus[7:5] = 001, non-specific EOI: clear the highest-priority set ISR bit.
  - internal_bus[7:5] = 011, specific EOI: clear in_service[internal_bus[2:0]].
  - Any other code: no effect.
- Simultaneous events:
  - An ISR set in ACK1 and an EOI in the same cycle: the EOI acts on the pre-set ISR value, and the set still applies.
  - ICW_1_flag overrides every other event in its cycle.
- Reset mid-sequence: return to IDLE. vector_out_en = 0 next cycle. No AEOI clear is performed.

## Timing
- Reset values: INT = 0, clear_irr = 0, in_service = 0, vector_out = 0, vector_out_en = 0. vector_base = VECTOR_BASE_RESET, aeoi = 0, state = IDLE.
- INT is registered and follows a change in interrupt_request or ISR by 1 cycle.
- clear_irr and the ISR set appear 1 cycle after the first inta_bar fall is sampled.
- vector_out_en rises 1 cycle after the second fall is sampled and falls 1 cycle after the rise is sampled.
- Config and EOI effects are visible 1 cycle after the flag pulse.
- A fall while in ACK1 or ACK2 is ignored.

## Structure
- Shared package pic_pkg holds:
  - state enum {IDLE, ACK1, WAIT2, ACK2}
  - OCW2 command constants NS_EOI = 3'b001 and SP_EOI = 3'b011
  - SPURIOUS_LEVEL = 3'd7
- One sub-module, priority_resolver: 8-bit combinational lowest-index-wins encoder with a valid output. It is instantiated twice, once for requests and once for ISR.

## Test plan
- Reset, then ICW2 = 8'h40 and interrupt_request = 8'h20 -> INT = 1; first INTA gives clear_irr = 8'h20 and in_service = 8'h20; second INTA gives vector_out = 8'h45 with vector_out_en = 1.
- ISR = 8'h04, then interrupt_request = 8'h10 -> INT stays 0. Change interrupt_request to 8'h02 -> INT = 1 one cycle later.
- ICW4 with bit1 = 1, then a full INTA sequence on IR3 -> in_service returns to 8'h00 one cycle after the second inta_bar rise.
- ISR = 8'h0A: OCW2 = 8'h20 -> ISR = 8'h08. Then OCW2 = 8'h63 -> ISR = 8'h00.
- interrupt_request drops to 0 before the first INTA -> vector_out = {base, 3'd7}, ISR unchanged, clear_irr stays 0.
- ICW_1_flag during WAIT2 -> state IDLE and in_service = 0. A following inta_bar pulse produces no vector_out_en.
